// File: rtl/socket_arbiter.sv
// Round-robin frame arbiter: grants a full socket FIFO, pulls FRAME_LEN words, tags them onto one stream.
// Build option SOCKET_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module socket_arbiter #(
  parameter int N_SOCKETS  = 4,
  parameter int FRAME_LEN  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_SOCKETS-1:0]            i_full,
  input  logic [N_SOCKETS-1:0]            i_empty,
  input  logic [N_SOCKETS*DATA_WIDTH-1:0] i_data,
  input  logic                            i_ready,
  output logic [N_SOCKETS-1:0]            o_rd_en,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_dv,
  output logic                            o_sof,
  output logic                            o_eof,
  output logic [$clog2(N_SOCKETS)-1:0]    o_grant_id,
  output logic                            o_busy
);

  localparam int GW = $clog2(N_SOCKETS);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, PULL, GAP} state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        winner;
  logic                 found;
  logic [CW-1:0]        count;
  logic [N_SOCKETS-1:0] eligible;
  logic [N_SOCKETS-1:0] rd_en;

  logic                 s1_vld, s1_sof, s1_eof;
  logic [GW-1:0]        s1_grant;

  assign eligible = i_full & ~i_empty;

`ifdef SOCKET_ARBITER_FIXED_PRIO_EN
  // Descending scan so the lowest eligible index is the final assignment.
  always_comb begin
    logic [GW-1:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = N_SOCKETS - 1; i >= 0; i--) begin
      idx = GW'(i);
      if (eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
`else
  logic [GW-1:0] last_grant;

  // Scan offsets from farthest to nearest so the first eligible index after last_grant wins.
  always_comb begin
    logic [GW-1:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = N_SOCKETS; i >= 1; i--) begin
      idx = GW'((int'(last_grant) + i) % N_SOCKETS);
      if (eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant <= GW'(N_SOCKETS - 1);
    end else if (state == GAP) begin
      last_grant <= grant_q;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    rd_en     = '0;
    case (state)
      IDLE: if (i_ready && found) state_nxt = PULL;
      PULL: begin
        rd_en[grant_q] = 1'b1;
        if (count == LAST) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      count   <= '0;
      grant_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == PULL) begin
        grant_q <= winner;
        count   <= '0;
      end else if (state == PULL && count != LAST) begin
        count <= count + 1'b1;
      end
    end
  end

  // FIFO data lands one cycle after rd_en, so stage 1 carries the tags while the read completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld     <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eof     <= 1'b0;
      s1_grant   <= '0;
      o_dv       <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_grant_id <= '0;
      o_data     <= '0;
    end else begin
      s1_vld     <= (state == PULL);
      s1_sof     <= (state == PULL) && (count == '0);
      s1_eof     <= (state == PULL) && (count == LAST);
      s1_grant   <= grant_q;
      o_dv       <= s1_vld;
      o_sof      <= s1_sof;
      o_eof      <= s1_eof;
      o_grant_id <= s1_vld ? s1_grant : '0;
      o_data     <= s1_vld ? i_data[s1_grant*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  assign o_rd_en = rd_en;
  assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_socket_arbiter.sv
// Bench for socket_arbiter: vector table, directed corner sequences and randomized traffic
// against a timeline model that schedules each granted frame's reads and output words.
module tb_socket_arbiter;
  localparam int N = 4;
  localparam int F = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   full = '0;
  logic [N-1:0]   empty = '1;
  logic           ready = 1'b0;
  logic [N*W-1:0] data;
  logic [N-1:0]   rd_en;
  logic [W-1:0]   odat;
  logic           dv, sof, eof, busy;
  logic [1:0]     gid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  socket_arbiter #(.N_SOCKETS(N), .FRAME_LEN(F), .DATA_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_full(full), .i_empty(empty), .i_data(data),
    .i_ready(ready), .o_rd_en(rd_en), .o_data(odat), .o_dv(dv), .o_sof(sof),
    .o_eof(eof), .o_grant_id(gid), .o_busy(busy)
  );

  // Socket FIFO stand-ins: word = {socket, running read count}, valid one cycle after rd_en.
  logic [5:0] rcnt [N];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) rcnt[k] <= '0;
      data <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (rd_en[k]) begin
          data[k*W +: W] <= {2'(k), rcnt[k]};
          rcnt[k]        <= rcnt[k] + 6'd1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected-output timeline, indexed by cycle modulo 64.
  logic [N-1:0] e_rd   [64];
  logic         e_busy [64];
  logic         e_dv   [64];
  logic         e_sof  [64];
  logic         e_eof  [64];
  logic [1:0]   e_gid  [64];
  logic [7:0]   e_dat  [64];

  // Observed streams for the directed sequences.
  int sof_gid [$];
  int sof_cyc [$];
  logic [N-1:0] rd_q [$];
  logic [7:0] dv_dat [$];
  logic dv_sof [$];
  logic [1:0] dv_gid [$];

  initial begin : monitor
    int s, w, idle_from, last, t;
    logic found;
    logic [N-1:0] el;
    logic [5:0] mcnt [N];
    idle_from = 0;
    last = N - 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", {14'd0, rd_en, dv, sof, eof, gid, odat, busy}, 32'd0);
        for (int i = 0; i < 64; i++) begin
          e_rd[i] = '0; e_busy[i] = 0; e_dv[i] = 0; e_sof[i] = 0;
          e_eof[i] = 0; e_gid[i] = '0; e_dat[i] = '0;
        end
        for (int k = 0; k < N; k++) mcnt[k] = '0;
        last = N - 1;
        idle_from = 0;
      end else begin
        s = cyc % 64;
        check("rd_en", 32'(rd_en), 32'(e_rd[s]));
        check("busy", 32'(busy), 32'(e_busy[s]));
        check("dv", 32'(dv), 32'(e_dv[s]));
        if (e_dv[s]) begin
          check("data", 32'(odat), 32'(e_dat[s]));
          check("sof", 32'(sof), 32'(e_sof[s]));
          check("eof", 32'(eof), 32'(e_eof[s]));
          check("grant_id", 32'(gid), 32'(e_gid[s]));
        end
        if (rd_en != '0) rd_q.push_back(rd_en);
        if (dv) begin
          dv_dat.push_back(odat);
          dv_sof.push_back(sof);
          dv_gid.push_back(gid);
          if (sof) begin
            sof_gid.push_back(int'(gid));
            sof_cyc.push_back(cyc);
          end
        end
        e_rd[s] = '0; e_busy[s] = 0; e_dv[s] = 0; e_sof[s] = 0; e_eof[s] = 0;
        // Arbitration decision on the inputs the DUT samples at the coming edge.
        if (cyc >= idle_from && ready) begin
          el = full & ~empty;
          found = 0;
          w = 0;
`ifdef SOCKET_ARBITER_FIXED_PRIO_EN
          for (int i = 0; i < N; i++)
            if (!found && el[i]) begin found = 1; w = i; end
`else
          for (int off = 1; off <= N; off++) begin
            t = (last + off) % N;
            if (!found && el[t]) begin found = 1; w = t; end
          end
`endif
          if (found) begin
            for (int j = 0; j < F; j++) begin
              e_rd[(cyc + 1 + j) % 64]  = N'(1 << w);
              t = (cyc + 3 + j) % 64;
              e_dv[t]  = 1;
              e_sof[t] = (j == 0);
              e_eof[t] = (j == F - 1);
              e_gid[t] = 2'(w);
              e_dat[t] = {2'(w), 6'(mcnt[w] + 6'(j))};
            end
            for (int j = 1; j <= F + 1; j++) e_busy[(cyc + j) % 64] = 1;
            mcnt[w] = mcnt[w] + 6'(F);
            last = w;
            idle_from = cyc + F + 2;
          end
        end
      end
    end
  end

  typedef struct {
    logic [N-1:0] full;
    logic [N-1:0] empty;
    logic         ready;
    logic [N-1:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; full = '0; empty = '1; ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic clear_obs();
    sof_gid.delete(); sof_cyc.delete(); rd_q.delete();
    dv_dat.delete(); dv_sof.delete(); dv_gid.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{4'b0100, 4'b0000, 1'b1, 4'b0100};
    tbl[1] = '{4'b1111, 4'b0000, 1'b1, 4'b0001};
    tbl[2] = '{4'b1111, 4'b0001, 1'b1, 4'b0010};
    tbl[3] = '{4'b1010, 4'b0010, 1'b1, 4'b1000};
    tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0000};
    tbl[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0000};
    tbl[6] = '{4'b1111, 4'b0000, 1'b0, 4'b0000};
    tbl[7] = '{4'b1100, 4'b0000, 1'b1, 4'b0100};

    // Vector table: first arbitration after reset searches from socket 0.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      full = tbl[v].full; empty = tbl[v].empty; ready = tbl[v].ready;
      @(posedge clk); #1;
      check($sformatf("vec%0d_first_rd", v), 32'(rd_en), 32'(tbl[v].exp_rd));
      full = '0;
      idle_cycles(F + 4);
    end

    // Single socket 2, words 0x80..0x83.
    do_reset(); clear_obs();
    full = 4'b0100; empty = '0; ready = 1;
    idle_cycles(2);
    full = '0;
    idle_cycles(10);
    check("single_reads", 32'(rd_q.size()), 32'(F));
    check("single_words", 32'(dv_dat.size()), 32'(F));
    for (int i = 0; i < F && i < dv_dat.size(); i++) begin
      check($sformatf("single_dat%0d", i), 32'(dv_dat[i]), 32'(8'h80 + i));
      check($sformatf("single_gid%0d", i), 32'(dv_gid[i]), 32'd2);
    end

    // Fairness: sockets 0 and 1 continuously eligible for four frames.
    do_reset(); clear_obs();
    full = 4'b0011; empty = '0; ready = 1;
    idle_cycles(20);
    full = '0;
    idle_cycles(10);
    check("fair_frames", 32'(sof_gid.size()), 32'd4);
    for (int i = 0; i < 4 && i < sof_gid.size(); i++) begin
`ifdef SOCKET_ARBITER_FIXED_PRIO_EN
      check($sformatf("fair_grant%0d", i), 32'(sof_gid[i]), 32'd0);
`else
      check($sformatf("fair_grant%0d", i), 32'(sof_gid[i]), 32'(i % 2));
`endif
      if (i > 0) check($sformatf("fair_spacing%0d", i), 32'(sof_cyc[i] - sof_cyc[i-1]), 32'(F + 2));
    end

    // Backpressure: socket 3 eligible while ready is low.
    do_reset(); clear_obs();
    full = 4'b1000; empty = '0; ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_no_read", 32'(rd_en), 32'd0);
    end
    @(posedge clk); #1 ready = 1;
    @(negedge clk);
    check("bp_rise_cycle", 32'(rd_en), 32'd0);
    @(negedge clk);
    check("bp_start", 32'(rd_en), 32'b1000);
    full = '0;
    idle_cycles(10);

    // Flag drop mid-frame: still four reads and four words.
    do_reset(); clear_obs();
    full = 4'b0001; empty = '0; ready = 1;
    idle_cycles(3);
    full = '0;
    idle_cycles(10);
    check("flag_reads", 32'(rd_q.size()), 32'(F));
    check("flag_words", 32'(dv_dat.size()), 32'(F));

    // Reset after the second read of a socket-0 frame.
    do_reset(); clear_obs();
    full = 4'b0001; empty = '0; ready = 1;
    idle_cycles(3);
    rst = 1; full = 4'b0010;
    #1;
    check("rst_mid_outputs", {14'd0, rd_en, dv, sof, eof, gid, odat, busy}, 32'd0);
    @(posedge clk); #1 rst = 0;
    clear_obs();
    idle_cycles(2);
    full = '0;
    idle_cycles(10);
    check("rst_next_rd", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hdead, 32'b0010);
    check("rst_words", 32'(dv_dat.size()), 32'(F));
    if (dv_dat.size() > 0) begin
      check("rst_first_sof", 32'(dv_sof[0]), 32'd1);
      check("rst_first_gid", 32'(dv_gid[0]), 32'd1);
      check("rst_first_dat", 32'(dv_dat[0]), 32'h40);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 149) == 0);
      full  = N'($urandom);
      empty = N'($urandom) & N'($urandom);
      ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 0; full = '0; ready = 0;
    idle_cycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
